// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared bus addresses, FSM states and baud divisors for the SPART echo driver
package spart_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    // 100 MHz / (16 * baud) - 1
    localparam logic [15:0] DEFAULT_DIV_4800  = 16'h0515;
    localparam logic [15:0] DEFAULT_DIV_9600  = 16'h028A;
    localparam logic [15:0] DEFAULT_DIV_19200 = 16'h0144;
    localparam logic [15:0] DEFAULT_DIV_38400 = 16'h00A1;

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RD_DATA,
        WAIT_TBR,
        WR_DATA
    } state_t;

endpackage

// File: rtl/cfg_sync.sv
// rtl/cfg_sync.sv - br_cfg synchronizer, registered copy and pending-change flag
module cfg_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       load,
    output logic [1:0] cfg_q,
    output logic       change
);

    logic [1:0] sync_1;
    logic [1:0] sync_2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1 <= 2'b00;
            sync_2 <= 2'b00;
            cfg_q  <= 2'b00;
        end else begin
            sync_1 <= br_cfg;
            sync_2 <= sync_1;
            if (load) begin
                cfg_q <= sync_2;
            end
        end
    end

    // Stays asserted until the FSM accepts the new value, so changes mid-echo wait for IDLE.
    assign change = (sync_2 != cfg_q);

endmodule

// File: rtl/spart_echo_driver.sv
// rtl/spart_echo_driver.sv - SPART bus master: programs the baud divisor and echoes received bytes
module spart_echo_driver
    import spart_pkg::*;
#(
    parameter logic [15:0] DIV_4800  = DEFAULT_DIV_4800,
    parameter logic [15:0] DIV_9600  = DEFAULT_DIV_9600,
    parameter logic [15:0] DIV_19200 = DEFAULT_DIV_19200,
    parameter logic [15:0] DIV_38400 = DEFAULT_DIV_38400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] br_cfg,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus
);

    state_t      state;
    state_t      next_state;
    logic [7:0]  echo;
    logic [1:0]  cfg_q;
    logic        cfg_change;
    logic        cfg_load;
    logic [15:0] divisor;

    logic        acc_cs;
    logic        acc_rw;
    logic [1:0]  acc_addr;
    logic [7:0]  wdata;

    cfg_sync u_cfg_sync (
        .clk    (clk),
        .rst    (rst),
        .br_cfg (br_cfg),
        .load   (cfg_load),
        .cfg_q  (cfg_q),
        .change (cfg_change)
    );

    always_comb begin
        divisor = DIV_4800;
        case (cfg_q)
            2'b00:   divisor = DIV_4800;
            2'b01:   divisor = DIV_9600;
            2'b10:   divisor = DIV_19200;
            default: divisor = DIV_38400;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CFG_LO;
            echo  <= 8'h00;
        end else begin
            state <= next_state;
            // SPART drives the bus combinationally during the read strobe.
            if (state == RD_DATA) begin
                echo <= databus;
            end
        end
    end

    always_comb begin
        next_state = state;
        cfg_load   = 1'b0;
        acc_cs     = 1'b0;
        acc_rw     = 1'b1;
        acc_addr   = ADDR_DATA;
        wdata      = echo;
        case (state)
            CFG_LO: begin
                acc_cs     = 1'b1;
                acc_rw     = 1'b0;
                acc_addr   = ADDR_DB_LO;
                wdata      = divisor[7:0];
                next_state = CFG_HI;
            end
            CFG_HI: begin
                acc_cs     = 1'b1;
                acc_rw     = 1'b0;
                acc_addr   = ADDR_DB_HI;
                wdata      = divisor[15:8];
                next_state = IDLE;
            end
            IDLE: begin
                if (cfg_change) begin
                    cfg_load   = 1'b1;
                    next_state = CFG_LO;
                end else if (rda) begin
                    next_state = RD_DATA;
                end
            end
            RD_DATA: begin
                acc_cs     = 1'b1;
                next_state = WAIT_TBR;
            end
            WAIT_TBR: begin
                if (tbr) begin
                    next_state = WR_DATA;
                end
            end
            WR_DATA: begin
                acc_cs     = 1'b1;
                acc_rw     = 1'b0;
                next_state = IDLE;
            end
            default: begin
                next_state = CFG_LO;
            end
        endcase
    end

    // Gating with rst lets an asserted reset kill a strobe and release the bus without a clock edge.
    assign iocs    = acc_cs & rst;
    assign iorw    = acc_rw | ~rst;
    assign ioaddr  = rst ? acc_addr : ADDR_DATA;
    assign databus = (iocs && !iorw) ? wdata : 8'hzz;

endmodule

// File: tb/tb_spart_echo_driver.sv
// tb/tb_spart_echo_driver.sv - directed table-driven bench for spart_echo_driver
module tb_spart_echo_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       rda;
    logic       tbr;
    wire        iocs;
    wire        iorw;
    wire  [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] rx_byte;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    spart_echo_driver dut (
        .clk     (clk),
        .rst     (rst),
        .br_cfg  (br_cfg),
        .rda     (rda),
        .tbr     (tbr),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus)
    );

    // SPART side: returns rx_byte on a read strobe and holds 00 whenever iorw=1,
    // so a driver that fails to release the bus corrupts the observed value.
    assign databus = iorw ? (iocs ? rx_byte : 8'h00) : 8'hzz;

    typedef struct {
        logic       rda;
        logic       tbr;
        logic [1:0] cfg;
        logic [7:0] rx;
        logic       iocs;
        logic       iorw;
        logic [1:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t tbl_main[$];
    vec_t tbl_rst[$];

    function automatic vec_t mk(input logic r, input logic t, input logic [1:0] c, input logic [7:0] x,
                                input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] d);
        vec_t v;
        v.rda = r; v.tbr = t; v.cfg = c; v.rx = x;
        v.iocs = cs; v.iorw = rw; v.addr = a; v.data = d;
        return v;
    endfunction

    function automatic vec_t v_idle(input logic r, input logic t, input logic [1:0] c);
        return mk(r, t, c, 8'h00, 1'b0, 1'b1, 2'b00, 8'h00);
    endfunction

    function automatic vec_t v_wr(input logic [1:0] a, input logic [7:0] d,
                                  input logic r, input logic t, input logic [1:0] c);
        return mk(r, t, c, 8'h00, 1'b1, 1'b0, a, d);
    endfunction

    function automatic vec_t v_rd(input logic [7:0] x, input logic r, input logic t, input logic [1:0] c);
        return mk(r, t, c, x, 1'b1, 1'b1, 2'b00, x);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic run_vec(input string tag, input int i, input vec_t v);
        rx_byte = v.rx;
        #1;
        check($sformatf("%s%0d iocs", tag, i), {7'd0, iocs}, {7'd0, v.iocs});
        check($sformatf("%s%0d iorw", tag, i), {7'd0, iorw}, {7'd0, v.iorw});
        check($sformatf("%s%0d ioaddr", tag, i), {6'd0, ioaddr}, {6'd0, v.addr});
        check($sformatf("%s%0d databus", tag, i), databus, v.data);
        rda    = v.rda;
        tbr    = v.tbr;
        br_cfg = v.cfg;
        @(negedge clk);
    endtask

    initial begin
        // Reset release: sync flops start at 00, so 4800 is programmed first, then 9600.
        tbl_main.push_back(v_wr(2'b10, 8'h15, 1'b0, 1'b1, 2'b01));
        tbl_main.push_back(v_wr(2'b11, 8'h05, 1'b0, 1'b1, 2'b01));
        tbl_main.push_back(v_idle(1'b0, 1'b1, 2'b01));
        tbl_main.push_back(v_wr(2'b10, 8'h8A, 1'b0, 1'b1, 2'b01));
        tbl_main.push_back(v_wr(2'b11, 8'h02, 1'b0, 1'b1, 2'b01));
        // Single echo of 41 with tbr already high.
        tbl_main.push_back(v_idle(1'b1, 1'b1, 2'b01));
        tbl_main.push_back(v_rd(8'h41, 1'b0, 1'b1, 2'b01));
        tbl_main.push_back(v_idle(1'b0, 1'b1, 2'b01));
        tbl_main.push_back(v_wr(2'b00, 8'h41, 1'b0, 1'b1, 2'b01));
        // rda held high, tbr low for 20 cycles.
        tbl_main.push_back(v_idle(1'b1, 1'b0, 2'b01));
        tbl_main.push_back(v_rd(8'h5C, 1'b1, 1'b0, 2'b01));
        for (int k = 0; k < 19; k++) tbl_main.push_back(v_idle(1'b1, 1'b0, 2'b01));
        tbl_main.push_back(v_idle(1'b1, 1'b1, 2'b01));
        tbl_main.push_back(v_wr(2'b00, 8'h5C, 1'b0, 1'b0, 2'b01));
        // br_cfg 01 -> 11 while waiting for tbr.
        tbl_main.push_back(v_idle(1'b1, 1'b0, 2'b01));
        tbl_main.push_back(v_rd(8'h7E, 1'b0, 1'b0, 2'b11));
        tbl_main.push_back(v_idle(1'b0, 1'b0, 2'b11));
        tbl_main.push_back(v_idle(1'b0, 1'b0, 2'b11));
        tbl_main.push_back(v_idle(1'b0, 1'b1, 2'b11));
        tbl_main.push_back(v_wr(2'b00, 8'h7E, 1'b0, 1'b1, 2'b11));
        tbl_main.push_back(v_idle(1'b0, 1'b1, 2'b11));
        tbl_main.push_back(v_wr(2'b10, 8'hA1, 1'b0, 1'b1, 2'b11));
        tbl_main.push_back(v_wr(2'b11, 8'h00, 1'b0, 1'b1, 2'b11));
        tbl_main.push_back(v_idle(1'b1, 1'b1, 2'b11));

        // After a mid-write reset: restart at CFG_LO with cfg_q cleared, then pick up 11 again.
        tbl_rst.push_back(v_wr(2'b10, 8'h15, 1'b0, 1'b1, 2'b11));
        tbl_rst.push_back(v_wr(2'b11, 8'h05, 1'b0, 1'b1, 2'b11));
        tbl_rst.push_back(v_idle(1'b0, 1'b1, 2'b11));
        tbl_rst.push_back(v_wr(2'b10, 8'hA1, 1'b0, 1'b1, 2'b11));
        tbl_rst.push_back(v_wr(2'b11, 8'h00, 1'b0, 1'b1, 2'b11));
        tbl_rst.push_back(v_idle(1'b0, 1'b1, 2'b11));

        rst = 1'b0; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b1; rx_byte = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("reset iocs", {7'd0, iocs}, 8'h00);
        check("reset iorw", {7'd0, iorw}, 8'h01);
        check("reset ioaddr", {6'd0, ioaddr}, 8'h00);
        check("reset databus", databus, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl_main[i]) run_vec("main", i, tbl_main[i]);

        // Read of 33 in progress, then reset asserted mid-write.
        rx_byte = 8'h33;
        #1;
        check("mid read iocs", {7'd0, iocs}, 8'h01);
        check("mid read iorw", {7'd0, iorw}, 8'h01);
        rda = 1'b0;
        @(negedge clk);
        #1;
        check("mid wait iocs", {7'd0, iocs}, 8'h00);
        @(negedge clk);
        #1;
        check("mid write iocs", {7'd0, iocs}, 8'h01);
        check("mid write databus", databus, 8'h33);
        #1;
        rst = 1'b0;
        #1;
        check("async rst iocs", {7'd0, iocs}, 8'h00);
        check("async rst iorw", {7'd0, iorw}, 8'h01);
        check("async rst ioaddr", {6'd0, ioaddr}, 8'h00);
        check("async rst databus", databus, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        foreach (tbl_rst[i]) run_vec("rst", i, tbl_rst[i]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
